// File: rtl/obstacle_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : obstacle_pkg
//  Description : Shared definitions for the obstacle producer and the
//                game-logic/collision consumer: slot count, field widths,
//                inactive-slot codes, playfield bounds, game modes and the
//                obstacle FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
package obstacle_pkg;

    localparam int NUM_OBS = 10;    // obstacle slots on the packed buses
    localparam int X_W     = 10;    // x coordinate width
    localparam int Y_W     = 9;     // y coordinate width

    // Inactive slot code; chosen so the consumer's overlap test never hits.
    localparam logic [X_W-1:0] X_NONE = '1;    // 1023
    localparam logic [Y_W-1:0] Y_NONE = '1;    // 511

    // Playfield vertical limits, shared with the consumer.
    localparam int UPPER_BOUND = 20;
    localparam int LOWER_BOUND = 460;

    // Shared game mode encoding.
    localparam logic [1:0] GM_INITIAL = 2'b00;
    localparam logic [1:0] GM_INGAME  = 2'b01;
    localparam logic [1:0] GM_PAUSED  = 2'b10;
    localparam logic [1:0] GM_ENDED   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCROLL = 2'd1,
        S_SPAWN  = 2'd2
    } obs_state_t;

endpackage : obstacle_pkg
`default_nettype wire

// File: rtl/obstacle_generator_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr16
//  Description : 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11
//                (right-shifting, toggle mask 16'hB400).
//  Ports       : clk  - clock
//                rst  - synchronous active-high load of seed
//                en   - advance one step this clock
//                seed - load value (must be nonzero)
//                q    - current LFSR state
//  Revision    : 1.0  initial release
// ============================================================================
module lfsr16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    localparam logic [15:0] c_TAPS = 16'hB400;

    logic [15:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= seed;
        end else if (en) begin
            r_q <= {1'b0, r_q[15:1]} ^ (r_q[0] ? c_TAPS : 16'h0000);
        end
    end

    assign q = r_q;

endmodule : lfsr16
`default_nettype wire

// File: rtl/obstacle_generator.sv
`default_nettype none
// ============================================================================
//  Module      : obstacle_generator
//  Description : Spawns, scrolls and retires up to NUM_OBS rectangular
//                obstacles, publishing them on packed buses for the
//                collision block. One frame_tick starts a SCROLL then SPAWN
//                sequence; scroll results appear one cycle after the tick
//                edge, spawn results two cycles after.
//  Ports       : clk              - system clock
//                rst              - synchronous active-high reset
//                gamemode[1:0]    - 00 initial, 01 in-game, 10 paused, 11 ended
//                frame_tick       - one-cycle pulse per video frame
//                obstacle_x[199:0]- slot k: [k*20+:10] x_left, [k*20+10+:10] x_right
//                obstacle_y[179:0]- slot k: [k*18+:9] y_top, [k*18+9+:9] y_bottom
//                obstacles_passed - retired obstacle count, saturating at 255
//                busy             - high while the FSM is not idle
//  Options     : OBSTACLE_SPEEDUP_EN - scroll step grows by 1 every 8
//                successful spawns, capped at 12.
//  Revision    : 1.0  initial release
// ============================================================================
module obstacle_generator
    import obstacle_pkg::*;
#(
    parameter int          SCREEN_W       = 640,
    parameter int          OBS_WIDTH      = 40,
    parameter int          OBS_HEIGHT     = 60,
    parameter int          SCROLL_SPEED   = 4,
    parameter int          SPAWN_INTERVAL = 90,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   gamemode,
    input  logic         frame_tick,
    output logic [199:0] obstacle_x,
    output logic [179:0] obstacle_y,
    output logic [7:0]   obstacles_passed,
    output logic         busy
);

    localparam int c_CNT_W = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(SPAWN_INTERVAL - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [X_W-1:0]     c_SPAWN_XL  = X_W'(SCREEN_W);
    localparam logic [X_W-1:0]     c_SPAWN_XR  = X_W'(SCREEN_W + OBS_WIDTH - 1);
    localparam logic [Y_W-1:0]     c_Y_MIN     = Y_W'(UPPER_BOUND);
    localparam logic [Y_W-1:0]     c_Y_TOP_MAX = Y_W'(LOWER_BOUND - OBS_HEIGHT + 1);
    localparam logic [Y_W-1:0]     c_Y_SPAN    = Y_W'(OBS_HEIGHT - 1);

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic       w_clear;     // reset or initial mode: wipe everything
    logic       w_run;       // in-game: slots and counters may change
    obs_state_t r_state;
    obs_state_t w_state_nxt;
    logic       w_do_scroll;
    logic       w_do_spawn;

    assign w_clear = rst || (gamemode == GM_INITIAL);
    assign w_run   = (gamemode == GM_INGAME);

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ticks are only accepted from idle; once a sequence starts it runs to
    // completion regardless of mode, so pausing just parks the FSM in idle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (frame_tick && w_run) w_state_nxt = S_SCROLL;
            S_SCROLL: w_state_nxt = S_SPAWN;
            S_SPAWN:  w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // A sequence step finishing while paused/ended does not touch state.
    assign w_do_scroll = (r_state == S_SCROLL) && w_run;
    assign w_do_spawn  = (r_state == S_SPAWN)  && w_run;
    assign busy        = (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // Random source for the spawn height
    // ------------------------------------------------------------------
    logic [15:0] w_lfsr;
    logic        w_unused_lfsr;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (w_clear),
        .en   (1'b1),
        .seed (LFSR_SEED),
        .q    (w_lfsr)
    );

    assign w_unused_lfsr = &{1'b0, w_lfsr[15:9]};

    // ------------------------------------------------------------------
    // Spawn timing
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 w_attempt;
    logic                 w_spawn_ok;
    logic [NUM_OBS-1:0]   r_valid;
    logic [NUM_OBS-1:0]   w_sel;
    logic                 w_seen;

    assign w_attempt  = w_do_spawn && (r_cnt == c_CNT_LAST);
    assign w_spawn_ok = w_attempt && !(&r_valid);

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_cnt <= '0;
        end else if (w_do_spawn) begin
            r_cnt <= (r_cnt == c_CNT_LAST) ? '0 : (r_cnt + c_CNT_ONE);
        end
    end

    // One-hot select of the lowest-index free slot.
    always_comb begin
        w_sel  = '0;
        w_seen = 1'b0;
        for (int k = 0; k < NUM_OBS; k++) begin
            if (!r_valid[k] && !w_seen) begin
                w_sel[k] = 1'b1;
                w_seen   = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scroll step
    // ------------------------------------------------------------------
    logic [X_W-1:0] w_step;

`ifdef OBSTACLE_SPEEDUP_EN
    localparam logic [X_W-1:0] c_STEP_MAX = X_W'(12);
    localparam logic [X_W-1:0] c_STEP_ONE = X_W'(1);

    logic [X_W-1:0] r_step;
    logic [2:0]     r_spawn_mod8;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_step       <= X_W'(SCROLL_SPEED);
            r_spawn_mod8 <= 3'd0;
        end else if (w_spawn_ok) begin
            r_spawn_mod8 <= r_spawn_mod8 + 3'd1;
            if ((r_spawn_mod8 == 3'd7) && (r_step < c_STEP_MAX)) begin
                r_step <= r_step + c_STEP_ONE;
            end
        end
    end

    assign w_step = r_step;
`else
    assign w_step = X_W'(SCROLL_SPEED);
`endif

    // ------------------------------------------------------------------
    // Per-slot scroll results and new-obstacle height
    // ------------------------------------------------------------------
    logic [X_W-1:0] r_xl [NUM_OBS];
    logic [X_W-1:0] r_xr [NUM_OBS];
    logic [Y_W-1:0] r_yt [NUM_OBS];
    logic [Y_W-1:0] r_yb [NUM_OBS];

    logic [X_W-1:0]     w_xl_sc [NUM_OBS];
    logic [X_W-1:0]     w_xr_sc [NUM_OBS];
    logic [NUM_OBS-1:0] w_retire;
    logic [3:0]         w_ret_n;

    // Compare before subtract so nothing wraps below zero.
    always_comb begin
        w_retire = '0;
        w_ret_n  = 4'd0;
        for (int k = 0; k < NUM_OBS; k++) begin
            w_retire[k] = r_valid[k] && (r_xr[k] < w_step);
            w_xr_sc[k]  = r_xr[k] - w_step;
            w_xl_sc[k]  = (r_xl[k] < w_step) ? '0 : (r_xl[k] - w_step);
            w_ret_n     = w_ret_n + {3'b000, w_retire[k]};
        end
    end

    logic [Y_W-1:0] w_y_lo;
    logic [Y_W-1:0] w_ytop;
    logic [Y_W-1:0] w_ybot;

    // Clamp the random top into the band; the lower clamp compares the top
    // directly against its maximum so the 9-bit sum cannot overflow.
    assign w_y_lo = (w_lfsr[8:0] < c_Y_MIN) ? c_Y_MIN : w_lfsr[8:0];
    assign w_ytop = (w_y_lo > c_Y_TOP_MAX) ? c_Y_TOP_MAX : w_y_lo;
    assign w_ybot = w_ytop + c_Y_SPAN;

    // ------------------------------------------------------------------
    // Slot registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_clear) begin
            for (int k = 0; k < NUM_OBS; k++) begin
                r_xl[k] <= X_NONE;
                r_xr[k] <= X_NONE;
                r_yt[k] <= Y_NONE;
                r_yb[k] <= Y_NONE;
            end
            r_valid <= '0;
        end else begin
            for (int k = 0; k < NUM_OBS; k++) begin
                if (w_do_scroll && r_valid[k]) begin
                    if (w_retire[k]) begin
                        r_xl[k]    <= X_NONE;
                        r_xr[k]    <= X_NONE;
                        r_yt[k]    <= Y_NONE;
                        r_yb[k]    <= Y_NONE;
                        r_valid[k] <= 1'b0;
                    end else begin
                        r_xl[k] <= w_xl_sc[k];
                        r_xr[k] <= w_xr_sc[k];
                    end
                end else if (w_spawn_ok && w_sel[k]) begin
                    r_xl[k]    <= c_SPAWN_XL;
                    r_xr[k]    <= c_SPAWN_XR;
                    r_yt[k]    <= w_ytop;
                    r_yb[k]    <= w_ybot;
                    r_valid[k] <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Retired-obstacle score counter
    // ------------------------------------------------------------------
    logic [7:0] r_passed;
    logic [8:0] w_pass_sum;

    assign w_pass_sum = {1'b0, r_passed} + {5'b00000, w_ret_n};

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_passed <= 8'd0;
        end else if (w_do_scroll) begin
            r_passed <= w_pass_sum[8] ? 8'hFF : w_pass_sum[7:0];
        end
    end

    assign obstacles_passed = r_passed;

    // ------------------------------------------------------------------
    // Bus packing
    // ------------------------------------------------------------------
    always_comb begin
        obstacle_x = '0;
        obstacle_y = '0;
        for (int k = 0; k < NUM_OBS; k++) begin
            obstacle_x[k*20      +: 10] = r_xl[k];
            obstacle_x[k*20 + 10 +: 10] = r_xr[k];
            obstacle_y[k*18      +: 9]  = r_yt[k];
            obstacle_y[k*18 + 9  +: 9]  = r_yb[k];
        end
    end

endmodule : obstacle_generator
`default_nettype wire
